msx_slot_io_bridge: RTL and testbench
=====================================

// Module: msx_slot_io_bridge
// PURPOSE
// - Z80/MSX slot I/O front end of the VDP cartridge: samples async slot strobes/address/data in the clk domain.
// - Decodes the 4 VDP ports IO_BASE..IO_BASE+3 and issues one valid/ready transaction per access to the VDP core.
// - Returns read data onto slot_d and drives slot_wait (init hold and, optionally, busy back-pressure).
// PARAMETERS
// - IO_BASE      8'h88  base I/O port; ports IO_BASE+0..+3 decoded, slot_a[1:0] = register index
// - SYNC_STAGES  2      flip-flop stages on slot_iorq_n/slot_rd_n/slot_wr_n (min 2)
// PORTS
// - clk            in   1  85.90908 MHz system clock; single clock domain
// - reset_n        in   1  asynchronous active-low reset
// - init_done      in   1  high once SDRAM/VDP initialisation complete
// - slot_iorq_n    in   1  async Z80 /IORQ
// - slot_rd_n      in   1  async Z80 /RD
// - slot_wr_n      in   1  async Z80 /WR
// - slot_a         in   8  async Z80 A[7:0]
// - slot_d_in      in   8  slot data bus input
// - slot_d_out     out  8  read data to slot bus
// - slot_data_dir  out  1  1 = cartridge drives slot_d, 0 = input
// - slot_wait      out  1  1 = hold Z80 in wait
// - bus_valid      out  1  transaction request to VDP core
// - bus_ready      in   1  core accepts when bus_valid & bus_ready
// - bus_write      out  1  1 = write, 0 = read
// - bus_address    out  2  port index slot_a[1:0]
// - bus_wdata      out  8  write data
// - bus_rdata      in   8  read data from core
// - bus_rdata_en   in   1  one-cycle strobe qualifying bus_rdata
// BEHAVIOUR
// - Reset values: slot_d_out=8'h00, slot_data_dir=0, slot_wait=1, bus_valid=0, bus_write=0, bus_address=0, bus_wdata=0; state=IDLE.
// - slot_wait = ~init_done (registered) OR busy term (see CONFIGURATION); released 1 clk after init_done rises.
// - Strobes pass SYNC_STAGES FFs; iorq_wr = ~iorq_s & ~wr_s, iorq_rd = ~iorq_s & ~rd_s.
// - Access start = rising edge of iorq_wr or iorq_rd while slot_a[7:2]==IO_BASE[7:2] and init_done=1; slot_a/slot_d_in
//   captured that same cycle (stable >100 ns before strobes). Non-matching ports ignored entirely.
// - Both strobes active at once: illegal; write wins, read ignored.
// - FSM: IDLE -> REQ on access start; bus_valid=1 from next cycle.
//   REQ: hold bus_valid/bus_write/bus_address/bus_wdata stable until bus_valid&bus_ready; then write -> HOLD, read -> RD_WAIT.
//   RD_WAIT: on bus_rdata_en latch bus_rdata into slot_d_out -> HOLD.
//   HOLD: slot_data_dir=1 while read strobe still active and data latched; when both iorq_wr and iorq_rd are 0 ->
//   IDLE with slot_data_dir=0 in the same cycle. One transaction per strobe assertion; no re-trigger while held.
// - bus_rdata_en outside RD_WAIT ignored. bus_ready may be tied high (accept in 1 cycle).
// - Latency: strobe edge at pin -> bus_valid high = SYNC_STAGES+2 clk.
// - Strobe released during REQ/RD_WAIT (core too slow): transaction still completes, slot_data_dir stays 0, FSM -> IDLE.
// - reset_n low mid-transaction: immediate return to reset values; pending transaction discarded.
// CONFIGURATION
// - SLOT_WAIT_EN defined: slot_wait also 1 from access start until FSM reaches HOLD (write accepted / read data latched);
//   Z80 stretched so reads always return valid data.
// - SLOT_WAIT_EN undefined: slot_wait = ~init_done only; a read whose data is not latched before strobe release returns
//   nothing (slot_data_dir never asserted); write behaviour unchanged.
// TESTING
// - Reset, init_done=0 for 1000 clk -> slot_wait=1, bus_valid=0; raise init_done -> slot_wait=0 within 2 clk.
// - Z80 write port 8'h89 data 8'h0E, bus_ready=1 -> exactly one bus_valid pulse, bus_write=1, bus_address=1, bus_wdata=8'h0E.
// - bus_ready held 0 for 50 clk during write to 8'h88 -> request fields stable throughout, single accept at release.
// - Read port 8'h8A, core returns 8'hA5 after 10 clk -> slot_data_dir=1, slot_d_out=8'hA5 until /RD high, then dir=0.
// - Writes to 8'h98 and 8'h8C -> no bus_valid; 256 back-to-back writes to 8'h88 -> 256 accepted, data in order.
// - SLOT_WAIT_EN, read data delayed 200 clk -> slot_wait=1 until latch; reset_n pulsed in REQ -> all outputs at reset values.

Source files
------------

// File: rtl/msx_slot_io_bridge_if.sv
// -----------------------------------------------------------------------------
// msx_slot_io_bridge_if
// Request/response bus between the MSX slot I/O bridge and the VDP core.
//   bus_valid    master->slave  transaction request
//   bus_ready    slave->master  accept (transfer when bus_valid & bus_ready)
//   bus_write    master->slave  1 = write, 0 = read
//   bus_address  master->slave  VDP port index (slot_a[1:0])
//   bus_wdata    master->slave  write data
//   bus_rdata    slave->master  read data
//   bus_rdata_en slave->master  one-cycle strobe qualifying bus_rdata
// -----------------------------------------------------------------------------
interface msx_slot_io_bridge_if;
  logic       bus_valid;
  logic       bus_ready;
  logic       bus_write;
  logic [1:0] bus_address;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_rdata_en;

  modport master (
    output bus_valid, bus_write, bus_address, bus_wdata,
    input  bus_ready, bus_rdata, bus_rdata_en
  );

  modport slave (
    input  bus_valid, bus_write, bus_address, bus_wdata,
    output bus_ready, bus_rdata, bus_rdata_en
  );
endinterface

// File: rtl/msx_slot_io_bridge.sv
// -----------------------------------------------------------------------------
// msx_slot_io_bridge
// Z80/MSX slot I/O front end of the VDP cartridge. Synchronises the async slot
// strobes into clk, decodes the four VDP ports IO_BASE..IO_BASE+3 and issues
// one valid/ready transaction per Z80 I/O access. Read data is returned on
// slot_d_out with slot_data_dir; slot_wait holds the Z80 until init is done.
//
// Optional feature macro: SLOT_WAIT_EN
//   defined   : slot_wait is also held from access start until the write is
//               accepted or the read data is latched.
//   undefined : slot_wait = ~init_done only.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   init_done           SDRAM/VDP initialisation complete
//   slot_iorq_n/rd_n/wr_n  async Z80 strobes (active low)
//   slot_a, slot_d_in   Z80 address / data in (stable before strobes)
//   slot_d_out          read data to slot bus
//   slot_data_dir       1 = cartridge drives slot data bus
//   slot_wait           1 = hold Z80 in wait
//   bus                 master side of msx_slot_io_bridge_if
// -----------------------------------------------------------------------------
module msx_slot_io_bridge #(
  parameter logic [7:0]  IO_BASE     = 8'h88,
  parameter int unsigned SYNC_STAGES = 2       // must be >= 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       init_done,
  input  logic       slot_iorq_n,
  input  logic       slot_rd_n,
  input  logic       slot_wr_n,
  input  logic [7:0] slot_a,
  input  logic [7:0] slot_d_in,
  output logic [7:0] slot_d_out,
  output logic       slot_data_dir,
  output logic       slot_wait,
  msx_slot_io_bridge_if.master bus
);

`ifdef SLOT_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RD_WAIT,
    S_HOLD
  } state_t;

  // ---------------------------------------------------------------------------
  // Strobe synchronisers. Only the strobes are synchronised: slot_a and
  // slot_d_in are stable long before the strobes and are sampled directly
  // when the synchronised strobe edge is seen.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] iorq_sync_q;
  logic [SYNC_STAGES-1:0] rd_sync_q;
  logic [SYNC_STAGES-1:0] wr_sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, which is what makes a chain a chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iorq_sync_q <= '1;
      rd_sync_q   <= '1;
      wr_sync_q   <= '1;
    end else begin
      iorq_sync_q <= {iorq_sync_q[SYNC_STAGES-2:0], slot_iorq_n};
      rd_sync_q   <= {rd_sync_q[SYNC_STAGES-2:0],   slot_rd_n};
      wr_sync_q   <= {wr_sync_q[SYNC_STAGES-2:0],   slot_wr_n};
    end
  end

  logic iorq_wr;
  logic iorq_rd;
  assign iorq_wr = ~iorq_sync_q[SYNC_STAGES-1] & ~wr_sync_q[SYNC_STAGES-1];
  assign iorq_rd = ~iorq_sync_q[SYNC_STAGES-1] & ~rd_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Access detection: rising edge of a synchronised I/O strobe on a VDP port.
  // A write edge wins over a simultaneous read (illegal bus state).
  // ---------------------------------------------------------------------------
  logic iorq_wr_q;
  logic iorq_rd_q;
  logic start_wr;
  logic start_rd;
  logic port_hit;
  logic access_start;

  assign start_wr     = iorq_wr & ~iorq_wr_q;
  assign start_rd     = iorq_rd & ~iorq_rd_q & ~iorq_wr;
  assign port_hit     = (slot_a[7:2] == IO_BASE[7:2]);
  assign access_start = (start_wr | start_rd) & port_hit & init_done;

  // ---------------------------------------------------------------------------
  // Transaction FSM with registered outputs.
  // released_q remembers that the Z80 let go of the strobe before the core
  // finished, so a late HOLD never drives the bus for an unrelated access.
  // ---------------------------------------------------------------------------
  state_t     state_q;
  logic       valid_q;
  logic       write_q;
  logic [1:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] d_out_q;
  logic       dir_q;
  logic       wait_q;
  logic       released_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= 2'd0;
      wdata_q    <= 8'h00;
      d_out_q    <= 8'h00;
      dir_q      <= 1'b0;
      wait_q     <= 1'b1;
      released_q <= 1'b0;
      iorq_wr_q  <= 1'b0;
      iorq_rd_q  <= 1'b0;
    end else begin
      iorq_wr_q <= iorq_wr;
      iorq_rd_q <= iorq_rd;
      // Later assignments in the case below override this default.
      wait_q    <= ~init_done;

      case (state_q)
        S_IDLE: begin
          dir_q <= 1'b0;
          if (access_start) begin
            state_q    <= S_REQ;
            write_q    <= start_wr;
            addr_q     <= slot_a[1:0];
            wdata_q    <= slot_d_in;
            released_q <= 1'b0;
            if (WAIT_EN) wait_q <= 1'b1;
          end
        end

        S_REQ: begin
          if (WAIT_EN) wait_q <= 1'b1;
          if (!iorq_wr && !iorq_rd) released_q <= 1'b1;
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (bus.bus_ready) begin
            valid_q <= 1'b0;
            if (write_q) begin
              state_q <= S_HOLD;
              wait_q  <= ~init_done;
            end else begin
              state_q <= S_RD_WAIT;
            end
          end
        end

        S_RD_WAIT: begin
          if (WAIT_EN) wait_q <= 1'b1;
          if (!iorq_wr && !iorq_rd) released_q <= 1'b1;
          if (bus.bus_rdata_en) begin
            d_out_q <= bus.bus_rdata;
            dir_q   <= iorq_rd & ~released_q;
            state_q <= S_HOLD;
            wait_q  <= ~init_done;
          end
        end

        S_HOLD: begin
          if (released_q || (!iorq_wr && !iorq_rd)) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
          end else begin
            dir_q <= dir_q & iorq_rd;
          end
        end

        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          dir_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bus_valid   = valid_q;
  assign bus.bus_write   = write_q;
  assign bus.bus_address = addr_q;
  assign bus.bus_wdata   = wdata_q;
  assign slot_d_out      = d_out_q;
  assign slot_data_dir   = dir_q;
  assign slot_wait       = wait_q;

endmodule

// File: tb/tb_msx_slot_io_bridge.sv
// -----------------------------------------------------------------------------
// tb_msx_slot_io_bridge
// Self-checking bench for msx_slot_io_bridge. Expected bus transactions are
// pushed to a scoreboard queue when Z80 stimulus is driven and popped when the
// DUT's transfer (bus_valid & bus_ready) is observed. Inputs change 1 time
// unit after the rising edge; outputs are sampled on the falling edge.
// Builds with or without SLOT_WAIT_EN.
// -----------------------------------------------------------------------------
module tb_msx_slot_io_bridge;

  typedef struct {
    logic       write;
    logic [1:0] addr;
    logic [7:0] data;
  } txn_t;

  logic       clk;
  logic       reset_n;
  logic       init_done;
  logic       slot_iorq_n;
  logic       slot_rd_n;
  logic       slot_wr_n;
  logic [7:0] slot_a;
  logic [7:0] slot_d_in;
  logic [7:0] slot_d_out;
  logic       slot_data_dir;
  logic       slot_wait;

  msx_slot_io_bridge_if bus_if ();

  msx_slot_io_bridge #(
    .IO_BASE     (8'h88),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .init_done     (init_done),
    .slot_iorq_n   (slot_iorq_n),
    .slot_rd_n     (slot_rd_n),
    .slot_wr_n     (slot_wr_n),
    .slot_a        (slot_a),
    .slot_d_in     (slot_d_in),
    .slot_d_out    (slot_d_out),
    .slot_data_dir (slot_data_dir),
    .slot_wait     (slot_wait),
    .bus           (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

  txn_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Sampled view of the DUT, refreshed every falling edge by tick().
  logic       s_valid, s_write, s_dir, s_wait;
  logic [1:0] s_addr;
  logic [7:0] s_wdata, s_dout;
  int         acc_cnt   = 0;
  int         valid_cnt = 0;
  int         dir_cnt   = 0;
  int         wait_cnt  = 0;

  // One clock: sample at the falling edge, score any transfer, then return
  // just after the next rising edge so the caller can drive inputs.
  task automatic tick();
    txn_t t;
    @(negedge clk);
    s_valid = bus_if.bus_valid;
    s_write = bus_if.bus_write;
    s_addr  = bus_if.bus_address;
    s_wdata = bus_if.bus_wdata;
    s_dir   = slot_data_dir;
    s_wait  = slot_wait;
    s_dout  = slot_d_out;
    if (s_valid === 1'b1) valid_cnt++;
    if (s_dir   === 1'b1) dir_cnt++;
    if (s_wait  === 1'b1) wait_cnt++;
    if (reset_n && s_valid === 1'b1 && bus_if.bus_ready === 1'b1) begin
      acc_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL txn_unexpected: got w=%0b a=%0d d=%02h, required no transaction",
                 s_write, s_addr, s_wdata);
      end else begin
        t = exp_q.pop_front();
        if (s_write !== t.write || s_addr !== t.addr || (t.write && s_wdata !== t.data)) begin
          errors++;
          $display("FAIL txn_fields: got w=%0b a=%0d d=%02h, required w=%0b a=%0d d=%02h",
                   s_write, s_addr, s_wdata, t.write, t.addr, t.data);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic w, input logic [1:0] a, input logic [7:0] d);
    txn_t t;
    t.write = w;
    t.addr  = a;
    t.data  = d;
    exp_q.push_back(t);
  endtask

  // Address/data set up two clocks before the strobes, as on a real Z80 cycle.
  task automatic io_start(input logic [7:0] port, input logic [7:0] data, input logic is_write);
    slot_a    = port;
    slot_d_in = data;
    tick();
    tick();
    slot_iorq_n = 1'b0;
    if (is_write) slot_wr_n = 1'b0;
    else          slot_rd_n = 1'b0;
  endtask

  task automatic io_end();
    slot_iorq_n = 1'b1;
    slot_rd_n   = 1'b1;
    slot_wr_n   = 1'b1;
  endtask

  task automatic z80_write(input logic [7:0] port, input logic [7:0] data, input int hold);
    io_start(port, data, 1'b1);
    repeat (hold) tick();
    io_end();
    repeat (6) tick();
  endtask

  // Waits for the next transfer; an expired budget is a failed comparison.
  task automatic wait_accept(input string name, input int budget);
    int start_cnt;
    start_cnt = acc_cnt;
    for (int i = 0; i < budget && acc_cnt == start_cnt; i++) tick();
    checks++;
    if (acc_cnt == start_cnt) begin
      errors++;
      $display("FAIL %s: no transfer within %0d clk, required one", name, budget);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int w0, v0;
    reset_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (s_valid !== 1'b0 || s_write !== 1'b0 || s_addr !== 2'd0 || s_wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus: got v=%0b w=%0b a=%0d d=%02h, required all zero",
               s_valid, s_write, s_addr, s_wdata);
    end
    checks++;
    if (s_dout !== 8'h00 || s_dir !== 1'b0 || s_wait !== 1'b1) begin
      errors++;
      $display("FAIL reset_slot: got dout=%02h dir=%0b wait=%0b, required 00/0/1",
               s_dout, s_dir, s_wait);
    end
    reset_n = 1'b1;
    w0 = wait_cnt;
    v0 = valid_cnt;
    // A VDP-port write while init is pending must be ignored.
    for (int i = 0; i < 1000; i++) begin
      if (i == 100) begin
        slot_a = 8'h88; slot_d_in = 8'h11;
        slot_iorq_n = 1'b0; slot_wr_n = 1'b0;
      end
      if (i == 140) io_end();
      tick();
    end
    checks++;
    if (wait_cnt - w0 != 1000) begin
      errors++;
      $display("FAIL init_wait: got wait high %0d of 1000 clk, required 1000", wait_cnt - w0);
    end
    checks++;
    if (valid_cnt - v0 != 0) begin
      errors++;
      $display("FAIL init_no_valid: got %0d valid clk, required 0", valid_cnt - v0);
    end
    init_done = 1'b1;
    tick();
    tick();
    checks++;
    if (s_wait !== 1'b0) begin
      errors++;
      $display("FAIL init_release: got slot_wait=%0b 2 clk after init_done, required 0", s_wait);
    end
  endtask

  task automatic test_write_single();
    int v0, a0;
    bus_if.bus_ready = 1'b1;
    v0 = valid_cnt;
    a0 = acc_cnt;
    push_exp(1'b1, 2'd1, 8'h0E);
    io_start(8'h89, 8'h0E, 1'b1);
    repeat (4) tick();
    checks++;
    if (s_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got bus_valid=%0b 3 clk after strobe, required 0", s_valid);
    end
    tick();
    checks++;
    if (s_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: got bus_valid=%0b 4 clk after strobe, required 1", s_valid);
    end
    checks++;
    if (s_write !== 1'b1 || s_addr !== 2'd1 || s_wdata !== 8'h0E) begin
      errors++;
      $display("FAIL write_fields: got w=%0b a=%0d d=%02h, required 1/1/0e",
               s_write, s_addr, s_wdata);
    end
    repeat (25) tick();
    io_end();
    repeat (6) tick();
    checks++;
    if (valid_cnt - v0 != 1 || acc_cnt - a0 != 1) begin
      errors++;
      $display("FAIL write_single_pulse: got %0d valid clk / %0d transfers, required 1/1",
               valid_cnt - v0, acc_cnt - a0);
    end
  endtask

  task automatic test_ready_stall();
    int  a0;
    bit  stable;
    bus_if.bus_ready = 1'b0;
    a0 = acc_cnt;
    push_exp(1'b1, 2'd0, 8'h5A);
    io_start(8'h88, 8'h5A, 1'b1);
    for (int i = 0; i < 20 && s_valid !== 1'b1; i++) tick();
    checks++;
    if (s_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_valid: got bus_valid=%0b after 20 clk, required 1", s_valid);
    end
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 20) io_end();   // strobe released while the core stalls
      tick();
      if (s_valid !== 1'b1 || s_write !== 1'b1 || s_addr !== 2'd0 || s_wdata !== 8'h5A)
        stable = 1'b0;
    end
    checks++;
    if (!stable || acc_cnt != a0) begin
      errors++;
      $display("FAIL stall_stable: got stable=%0b transfers=%0d, required 1/0",
               stable, acc_cnt - a0);
    end
    bus_if.bus_ready = 1'b1;
    repeat (8) tick();
    checks++;
    if (acc_cnt - a0 != 1 || s_valid !== 1'b0 || s_dir !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got transfers=%0d valid=%0b dir=%0b, required 1/0/0",
               acc_cnt - a0, s_valid, s_dir);
    end
  endtask

  task automatic test_read();
    bus_if.bus_ready = 1'b1;
    // Stray data strobe while idle must not reach slot_d_out.
    bus_if.bus_rdata    = 8'h33;
    bus_if.bus_rdata_en = 1'b1;
    tick();
    bus_if.bus_rdata_en = 1'b0;
    tick();
    tick();
    checks++;
    if (s_dout !== 8'h00) begin
      errors++;
      $display("FAIL rdata_en_idle: got slot_d_out=%02h, required 00", s_dout);
    end
    push_exp(1'b0, 2'd2, 8'h00);
    io_start(8'h8A, 8'h00, 1'b0);
    wait_accept("read_accept", 20);
    repeat (9) tick();
    bus_if.bus_rdata    = 8'hA5;
    bus_if.bus_rdata_en = 1'b1;
    tick();
    bus_if.bus_rdata_en = 1'b0;
    bus_if.bus_rdata    = 8'h00;
    repeat (3) tick();
    checks++;
    if (s_dir !== 1'b1 || s_dout !== 8'hA5) begin
      errors++;
      $display("FAIL read_data: got dir=%0b dout=%02h, required 1/a5", s_dir, s_dout);
    end
    repeat (10) tick();
    checks++;
    if (s_dir !== 1'b1) begin
      errors++;
      $display("FAIL read_hold: got dir=%0b while /RD low, required 1", s_dir);
    end
    io_end();
    repeat (5) tick();
    checks++;
    if (s_dir !== 1'b0) begin
      errors++;
      $display("FAIL read_release: got dir=%0b after /RD high, required 0", s_dir);
    end
  endtask

  task automatic test_ignored_ports();
    int v0;
    bus_if.bus_ready = 1'b1;
    v0 = valid_cnt;
    z80_write(8'h98, 8'h12, 15);
    z80_write(8'h8C, 8'h34, 15);
    checks++;
    if (valid_cnt != v0) begin
      errors++;
      $display("FAIL ignored_ports: got %0d valid clk, required 0", valid_cnt - v0);
    end
  endtask

  task automatic test_back_to_back();
    int a0;
    bus_if.bus_ready = 1'b1;
    a0 = acc_cnt;
    for (int i = 0; i < 256; i++) begin
      push_exp(1'b1, 2'd0, 8'(i));
      z80_write(8'h88, 8'(i), 10);
    end
    checks++;
    if (acc_cnt - a0 != 256 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back: got %0d transfers, %0d pending, required 256/0",
               acc_cnt - a0, exp_q.size());
    end
  endtask

  task automatic test_slow_read();
    int w0, d0;
    bus_if.bus_ready = 1'b1;
    push_exp(1'b0, 2'd3, 8'h00);
    io_start(8'h8B, 8'h00, 1'b0);
    wait_accept("slow_accept", 20);
    w0 = wait_cnt;
    d0 = dir_cnt;
`ifdef SLOT_WAIT_EN
    repeat (200) tick();
    checks++;
    if (wait_cnt - w0 != 200) begin
      errors++;
      $display("FAIL slow_wait: got wait high %0d of 200 clk, required 200", wait_cnt - w0);
    end
    bus_if.bus_rdata    = 8'hC3;
    bus_if.bus_rdata_en = 1'b1;
    tick();
    bus_if.bus_rdata_en = 1'b0;
    repeat (2) tick();
    checks++;
    if (s_wait !== 1'b0 || s_dir !== 1'b1 || s_dout !== 8'hC3) begin
      errors++;
      $display("FAIL slow_latch: got wait=%0b dir=%0b dout=%02h, required 0/1/c3",
               s_wait, s_dir, s_dout);
    end
    io_end();
    repeat (5) tick();
`else
    for (int i = 0; i < 200; i++) begin
      if (i == 20) io_end();   // Z80 is not stretched and finishes its cycle
      tick();
    end
    bus_if.bus_rdata    = 8'hC3;
    bus_if.bus_rdata_en = 1'b1;
    tick();
    bus_if.bus_rdata_en = 1'b0;
    repeat (5) tick();
    checks++;
    if (wait_cnt != w0 || dir_cnt != d0) begin
      errors++;
      $display("FAIL slow_no_drive: got wait clk=%0d dir clk=%0d, required 0/0",
               wait_cnt - w0, dir_cnt - d0);
    end
    checks++;
    if (s_dout !== 8'hC3) begin
      errors++;
      $display("FAIL slow_latch: got slot_d_out=%02h, required c3", s_dout);
    end
`endif
    checks++;
    if (s_dir !== 1'b0) begin
      errors++;
      $display("FAIL slow_idle: got dir=%0b, required 0", s_dir);
    end
  endtask

  task automatic test_reset_mid();
    int a0, v0;
    bus_if.bus_ready = 1'b0;
    push_exp(1'b1, 2'd1, 8'h77);
    io_start(8'h89, 8'h77, 1'b1);
    for (int i = 0; i < 20 && s_valid !== 1'b1; i++) tick();
    checks++;
    if (s_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_req: got bus_valid=%0b, required 1 before reset", s_valid);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus_if.bus_valid !== 1'b0 || bus_if.bus_write !== 1'b0 ||
        bus_if.bus_address !== 2'd0 || bus_if.bus_wdata !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_bus: got v=%0b w=%0b a=%0d d=%02h, required all zero",
               bus_if.bus_valid, bus_if.bus_write, bus_if.bus_address, bus_if.bus_wdata);
    end
    checks++;
    if (slot_d_out !== 8'h00 || slot_data_dir !== 1'b0 || slot_wait !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_slot: got dout=%02h dir=%0b wait=%0b, required 00/0/1",
               slot_d_out, slot_data_dir, slot_wait);
    end
    exp_q.delete();            // the pending transaction is discarded
    io_end();
    tick();
    tick();
    reset_n = 1'b1;
    bus_if.bus_ready = 1'b1;
    a0 = acc_cnt;
    v0 = valid_cnt;
    repeat (10) tick();
    checks++;
    if (acc_cnt != a0 || valid_cnt != v0 || s_wait !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after: got transfers=%0d valid clk=%0d wait=%0b, required 0/0/0",
               acc_cnt - a0, valid_cnt - v0, s_wait);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    reset_n             = 1'b0;
    init_done           = 1'b0;
    slot_iorq_n         = 1'b1;
    slot_rd_n           = 1'b1;
    slot_wr_n           = 1'b1;
    slot_a              = 8'h00;
    slot_d_in           = 8'h00;
    bus_if.bus_ready    = 1'b1;
    bus_if.bus_rdata    = 8'h00;
    bus_if.bus_rdata_en = 1'b0;

    test_reset();
    test_write_single();
    test_ready_stall();
    test_read();
    test_ignored_ports();
    test_back_to_back();
    test_slow_read();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
